// File: rtl/sample_sched_pkg.sv
// Shared definitions for the ADC sample sequencer: default widths and FSM encoding.
package sample_sched_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned PACK_DEF       = 4;
    localparam int unsigned CNT_WIDTH_DEF  = 32;
    localparam int unsigned DEC_WIDTH_DEF  = 8;
    localparam int unsigned LEN_WIDTH_DEF  = 16;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_START = 2'd1;
    localparam logic [1:0] ST_RUN        = 2'd2;
    localparam logic [1:0] ST_DRAIN      = 2'd3;

    typedef enum logic [1:0] {
        StIdle      = ST_IDLE,
        StWaitStart = ST_WAIT_START,
        StRun       = ST_RUN,
        StDrain     = ST_DRAIN
    } state_e;

endpackage

// File: rtl/sample_packer.sv
// Decimates offered samples and packs kept ones into words, first kept sample in the LSBs.
module sample_packer
    import sample_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PACK       = PACK_DEF,
    parameter int unsigned DEC_WIDTH  = DEC_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       keep_in,
    input  logic [DATA_WIDTH-1:0]      sample,
    input  logic [DEC_WIDTH-1:0]       dec,
    output logic                       word_done,
    output logic [DATA_WIDTH*PACK-1:0] word
);

    localparam int unsigned SLOT_W = $clog2(PACK);
    localparam int unsigned SR_W   = (PACK - 1) * DATA_WIDTH;

    logic [DEC_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [SR_W-1:0]      sr_q, sr_d;
    logic                 kept;

    assign kept      = keep_in && (dec_cnt_q == '0);
    assign word_done = kept && (slot_q == SLOT_W'(PACK - 1));
    // The completing sample is combined directly so the word is ready in its own cycle.
    assign word      = {sample, sr_q};

    always_comb begin
        dec_cnt_d = dec_cnt_q;
        slot_d    = slot_q;
        sr_d      = sr_q;
        if (clear) begin
            dec_cnt_d = '0;
            slot_d    = '0;
        end else if (kept) begin
            dec_cnt_d = dec;
            sr_d      = SR_W'(word >> DATA_WIDTH);
            slot_d    = word_done ? '0 : slot_q + SLOT_W'(1);
        end else if (keep_in) begin
            dec_cnt_d = dec_cnt_q - DEC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt_q <= '0;
            slot_q    <= '0;
            sr_q      <= '0;
        end else begin
            dec_cnt_q <= dec_cnt_d;
            slot_q    <= slot_d;
            sr_q      <= sr_d;
        end
    end

endmodule

// File: rtl/sample_sched.sv
// ADC sample sequencer: armed capture start on a sample index, decimate/pack, framed write port.
module sample_sched
    import sample_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PACK       = PACK_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int unsigned DEC_WIDTH  = DEC_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_enable,
    input  logic [CNT_WIDTH-1:0]       cfg_start_cnt,
    input  logic [DEC_WIDTH-1:0]       cfg_dec,
    input  logic [LEN_WIDTH-1:0]       cfg_block_len,
    input  logic                       sample_valid,
    input  logic [DATA_WIDTH-1:0]      sample_data,
    output logic                       wr_valid,
    output logic [DATA_WIDTH*PACK-1:0] wr_data,
    output logic                       wr_last,
    input  logic                       wr_ready,
    output logic                       block_done,
    output logic                       overflow,
    input  logic                       clr_overflow,
    output logic [CNT_WIDTH-1:0]       sample_cnt,
    output logic                       busy
);

    state_e                     state_q, state_d;
    logic [CNT_WIDTH-1:0]       sample_cnt_q, sample_cnt_d;
    logic                       hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH*PACK-1:0] hold_data_q, hold_data_d;
    logic                       hold_last_q, hold_last_d;
    logic [LEN_WIDTH-1:0]       blk_cnt_q, blk_cnt_d;
    logic                       block_done_q, block_done_d;
    logic                       overflow_q, overflow_d;

    logic                       start_hit, keep_in, clear;
    logic                       word_done, accept, load, drop, is_last;
    logic [DATA_WIDTH*PACK-1:0] word;

    assign start_hit = (state_q == StWaitStart) && sample_valid && (sample_cnt_q == cfg_start_cnt);
    assign keep_in   = start_hit || ((state_q == StRun) && cfg_enable && sample_valid);
    assign clear     = (state_q == StIdle) && cfg_enable;

    sample_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK       (PACK),
        .DEC_WIDTH  (DEC_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .keep_in   (keep_in),
        .sample    (sample_data),
        .dec       (cfg_dec),
        .word_done (word_done),
        .word      (word)
    );

    assign accept  = hold_valid_q && wr_ready;
    // A completed word may enter only if the register frees up in the same cycle.
    assign load    = word_done && (!hold_valid_q || wr_ready);
    assign drop    = word_done && hold_valid_q && !wr_ready;
    assign is_last = (blk_cnt_q == cfg_block_len);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (cfg_enable) state_d = StWaitStart;
            StWaitStart: begin
                if (start_hit)       state_d = StRun;
                else if (!cfg_enable) state_d = StIdle;
            end
            StRun:       if (!cfg_enable) state_d = StDrain;
            StDrain:     if (!hold_valid_q) state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        sample_cnt_d = sample_valid ? sample_cnt_q + CNT_WIDTH'(1) : sample_cnt_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        blk_cnt_d    = blk_cnt_q;
        block_done_d = accept && hold_last_q;
        overflow_d   = overflow_q;

        if (clear) blk_cnt_d = '0;
        if (load) begin
            hold_valid_d = 1'b1;
            hold_data_d  = word;
            hold_last_d  = is_last;
            blk_cnt_d    = is_last ? '0 : blk_cnt_q + LEN_WIDTH'(1);
        end else if (accept) begin
            hold_valid_d = 1'b0;
        end

        if (drop)              overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sample_cnt_q <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            blk_cnt_q    <= '0;
            block_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            blk_cnt_q    <= blk_cnt_d;
            block_done_q <= block_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign wr_valid   = hold_valid_q;
    assign wr_data    = hold_data_q;
    assign wr_last    = hold_last_q;
    assign block_done = block_done_q;
    assign overflow   = overflow_q;
    assign sample_cnt = sample_cnt_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_sample_sched.sv
// Scoreboard bench for sample_sched: directed sample streams, monitor pops expected words.
module tb_sample_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_enable;
    logic [3:0]  cfg_start_cnt;
    logic [7:0]  cfg_dec;
    logic [15:0] cfg_block_len;
    logic        sample_valid;
    logic [7:0]  sample_data;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_last;
    logic        wr_ready;
    logic        block_done;
    logic        overflow;
    logic        clr_overflow;
    logic [3:0]  sample_cnt;
    logic        busy;

    always #5 clk = ~clk;

    sample_sched #(
        .DATA_WIDTH (8),
        .PACK       (4),
        .CNT_WIDTH  (4),
        .DEC_WIDTH  (8),
        .LEN_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_enable    (cfg_enable),
        .cfg_start_cnt (cfg_start_cnt),
        .cfg_dec       (cfg_dec),
        .cfg_block_len (cfg_block_len),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .wr_ready      (wr_ready),
        .block_done    (block_done),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow),
        .sample_cnt    (sample_cnt),
        .busy          (busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          bd_seen = 0;
    logic        bd_exp = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] data_prev;
    logic        last_prev;
    exp_t        e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: compares accepted words, hold stability and block_done pulses.
    always @(negedge clk) begin
        if (bd_exp || block_done) check("block_done", 32'(block_done), 32'(bd_exp));
        if (block_done) bd_seen++;
        bd_exp = 1'b0;
        if (hold_prev) begin
            check("hold_valid", 32'(wr_valid), 32'd1);
            check("hold_data", wr_data, data_prev);
            check("hold_last", 32'(wr_last), 32'(last_prev));
        end
        hold_prev = wr_valid && !wr_ready && !rst;
        data_prev = wr_data;
        last_prev = wr_last;
        if (wr_valid && wr_ready && !rst) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h want none", wr_data);
            end else begin
                e = sb.pop_front();
                check("word_data", wr_data, e.data);
                check("word_last", 32'(wr_last), 32'(e.last));
                bd_exp = e.last;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        exp_t x;
        x.data = d;
        x.last = l;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            tick();
            n++;
        end
        check("drain_to_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
        check({tag, "_wr_data"}, wr_data, 32'd0);
        check({tag, "_wr_last"}, 32'(wr_last), 32'd0);
        check({tag, "_block_done"}, 32'(block_done), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_sample_cnt"}, 32'(sample_cnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        rst = 1'b1; cfg_enable = 1'b0; cfg_start_cnt = '0; cfg_dec = '0;
        cfg_block_len = 16'hFFFF; sample_valid = 1'b0; sample_data = '0;
        wr_ready = 1'b0; clr_overflow = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Start index 10, no decimation.
        cfg_start_cnt = 4'd10; cfg_dec = 8'd0; cfg_block_len = 16'hFFFF;
        wr_ready = 1'b1; cfg_enable = 1'b1;
        tick();
        check("busy_rise", 32'(busy), 32'd1);
        push(32'h0D0C0B0A, 1'b0);
        push(32'h11100F0E, 1'b0);
        for (int i = 0; i < 18; i++) begin
            send(8'(i));
            if (i == 12) check("valid_early", 32'(wr_valid), 32'd0);
            if (i == 13) begin
                check("valid_latency", 32'(wr_valid), 32'd1);
                check("first_word", wr_data, 32'h0D0C0B0A);
            end
        end
        check("cnt_after_18", 32'(sample_cnt), 32'd2);
        cfg_enable = 1'b0;
        wait_idle(10);

        // Decimation by 3 and blocks of 3 words.
        do_reset();
        cfg_start_cnt = 4'd0; cfg_dec = 8'd2; cfg_block_len = 16'd2; cfg_enable = 1'b1;
        tick();
        push(32'h09060300, 1'b0);
        for (int k = 1; k < 9; k++) begin
            b = 8'(12 * k);
            push({b + 8'd9, b + 8'd6, b + 8'd3, b}, (k % 3) == 2);
        end
        bd_seen = 0;
        for (int i = 0; i < 108; i++) send(8'(i));
        tick();
        tick();
        check("block_done_count", 32'(bd_seen), 32'd3);
        cfg_enable = 1'b0;
        wait_idle(10);

        // Backpressure: second word dropped, overflow set wins over clear.
        do_reset();
        cfg_start_cnt = 4'd0; cfg_dec = 8'd0; cfg_block_len = 16'hFFFF;
        wr_ready = 1'b0; cfg_enable = 1'b1;
        tick();
        push(32'h23222120, 1'b0);
        for (int i = 8'h20; i < 8'h27; i++) send(8'(i));
        check("no_ovf_yet", 32'(overflow), 32'd0);
        clr_overflow = 1'b1;
        send(8'h27);
        clr_overflow = 1'b0;
        check("ovf_set_over_clr", 32'(overflow), 32'd1);
        check("held_word", wr_data, 32'h23222120);
        tick();
        tick();
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);
        wr_ready = 1'b1;
        tick();
        push(32'h2B2A2928, 1'b0);
        for (int i = 8'h28; i < 8'h2C; i++) send(8'(i));
        tick();

        // Disable with a word pending and a partial word in the packer.
        wr_ready = 1'b0;
        push(32'h33323130, 1'b0);
        for (int i = 8'h30; i < 8'h36; i++) send(8'(i));
        cfg_enable = 1'b0;
        tick();
        tick();
        tick();
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_pending", 32'(wr_valid), 32'd1);
        wr_ready = 1'b1;
        wait_idle(10);
        check("drain_empty", 32'(wr_valid), 32'd0);

        // Counter wrap before the start index, then reset in RUN.
        do_reset();
        for (int i = 0; i < 14; i++) send(8'h00);
        check("cnt_preset", 32'(sample_cnt), 32'd14);
        cfg_start_cnt = 4'd1; cfg_dec = 8'd0; cfg_block_len = 16'hFFFF;
        wr_ready = 1'b1; cfg_enable = 1'b1;
        tick();
        push(32'h46454443, 1'b0);
        for (int i = 8'h40; i < 8'h47; i++) send(8'(i));
        check("cnt_wrap", 32'(sample_cnt), 32'd5);
        tick();
        wr_ready = 1'b0;
        for (int i = 8'h47; i < 8'h4F; i++) send(8'(i));
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrun_rst");
        rst = 1'b0;
        cfg_enable = 1'b0;
        tick();
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
